// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the fetch-stage PC generator.
// The source codes are also used by the debug trace to label each fetch.
package pc_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_DEFAULT   = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI_DEFAULT  = 32'h0000_6ffc;

    typedef enum logic [2:0] {
        PC_SRC_SEQ   = 3'd0,
        PC_SRC_REDIR = 3'd1,
        PC_SRC_PEND  = 3'd2,
        PC_SRC_EXC   = 3'd3,
        PC_SRC_ERET  = 3'd4,
        PC_SRC_HOLD  = 3'd5
    } pc_src_e;

    // Only these sources mark the pipeline contents as stale.
    function automatic logic srcFlushes(input pc_src_e src);
        return (src == PC_SRC_EXC) || (src == PC_SRC_ERET) || (src == PC_SRC_PEND);
    endfunction

endpackage

// File: rtl/pc_addr_check.sv
// Fetch-address legality test: word alignment plus inclusive instruction-memory window.
// Purely combinational so the D-stage jr target check can reuse it.
module pc_addr_check
    import pc_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] IMEM_LO = WIDTH'(IMEM_LO_DEFAULT),
    parameter logic [WIDTH-1:0] IMEM_HI = WIDTH'(IMEM_HI_DEFAULT)
) (
    input  logic [WIDTH-1:0] i_addr,
    output logic             o_err
);

    logic w_misaligned;
    logic w_below;
    logic w_above;

    assign w_misaligned = (i_addr[1:0] != 2'b00);
    assign w_below      = (i_addr < IMEM_LO);
    assign w_above      = (i_addr > IMEM_HI);
    assign o_err        = w_misaligned | w_below | w_above;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: priority next-PC selection, stall-time redirect
// buffering, and a registered address-error flag that travels with the PC.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(PC_RESET_DEFAULT),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(PC_EXC_DEFAULT),
    parameter logic [WIDTH-1:0] IMEM_LO    = WIDTH'(IMEM_LO_DEFAULT),
    parameter logic [WIDTH-1:0] IMEM_HI    = WIDTH'(IMEM_HI_DEFAULT)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_redir_valid,
    input  logic [WIDTH-1:0] i_redir_pc,
    input  logic             i_exc_req,
    input  logic             i_eret_req,
    input  logic [WIDTH-1:0] i_epc,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus4,
    output logic             o_pc_err,
    output logic             o_flush,
    output logic             o_pend_valid
);

    logic [WIDTH-1:0] r_pc;
    logic             r_pc_err;
    logic             r_flush;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_pend_pc;

    pc_src_e          w_src;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_next_err;

    assign w_pc_plus4 = r_pc + WIDTH'(4);

    // CP0 requests override the stall; a live redirect beats a buffered one.
    always_comb begin
        w_src = PC_SRC_SEQ;
        if (i_exc_req)
            w_src = PC_SRC_EXC;
        else if (i_eret_req)
            w_src = PC_SRC_ERET;
        else if (!i_en)
            w_src = PC_SRC_HOLD;
        else if (i_redir_valid)
            w_src = PC_SRC_REDIR;
        else if (r_pend_valid)
            w_src = PC_SRC_PEND;
    end

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (w_src)
            PC_SRC_EXC:   w_next_pc = EXC_VECTOR;
            PC_SRC_ERET:  w_next_pc = i_epc;
            PC_SRC_REDIR: w_next_pc = i_redir_pc;
            PC_SRC_PEND:  w_next_pc = r_pend_pc;
            PC_SRC_HOLD:  w_next_pc = r_pc;
            default:      w_next_pc = w_pc_plus4;
        endcase
    end

    pc_addr_check #(
        .WIDTH   (WIDTH),
        .IMEM_LO (IMEM_LO),
        .IMEM_HI (IMEM_HI)
    ) u_addr_check (
        .i_addr (w_next_pc),
        .o_err  (w_next_err)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc         <= RESET_PC;
            r_pc_err     <= 1'b0;
            r_flush      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
        end else begin
            r_flush <= srcFlushes(w_src);
            if (w_src == PC_SRC_HOLD) begin
                // The error flag stays with the held PC; only the buffer can change.
                if (i_redir_valid) begin
                    r_pend_pc    <= i_redir_pc;
                    r_pend_valid <= 1'b1;
                end
            end else begin
                r_pc     <= w_next_pc;
                r_pc_err <= w_next_err;
                if (w_src != PC_SRC_SEQ) begin
                    r_pend_valid <= 1'b0;
                    r_pend_pc    <= '0;
                end
            end
        end
    end

    assign o_pc         = r_pc;
    assign o_pc_plus4   = w_pc_plus4;
    assign o_pc_err     = r_pc_err;
    assign o_flush      = r_flush;
    assign o_pend_valid = r_pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: table-driven vectors through a scoreboard queue,
// plus a hand-written asynchronous reset in the middle of a stall.
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic        redirValid;
    logic [31:0] redirPc;
    logic        excReq;
    logic        eretReq;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        pcErr;
    logic        flush;
    logic        pendValid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        rv;
        logic [31:0] rpc;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] pc;
        logic        err;
        logic        flush;
        logic        pend;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        err;
        logic        flush;
        logic        pend;
    } exp_t;

    exp_t scoreboard[$];
    vec_t vecs[28];

    pc_gen dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_en          (en),
        .i_redir_valid (redirValid),
        .i_redir_pc    (redirPc),
        .i_exc_req     (excReq),
        .i_eret_req    (eretReq),
        .i_epc         (epc),
        .o_pc          (pc),
        .o_pc_plus4    (pcPlus4),
        .o_pc_err      (pcErr),
        .o_flush       (flush),
        .o_pend_valid  (pendValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic rv, input logic [31:0] rpc,
                                input logic x, input logic r, input logic [31:0] ep,
                                input logic [31:0] p, input logic er, input logic fl,
                                input logic pd);
        vec_t v;
        v.en = e; v.rv = rv; v.rpc = rpc; v.exc = x; v.eret = r; v.epc = ep;
        v.pc = p; v.err = er; v.flush = fl; v.pend = pd;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkState(input string name, input logic [31:0] ePc, input logic eErr,
                              input logic eFlush, input logic ePend);
        checkVal({name, ".pc"}, pc, ePc);
        checkVal({name, ".pc_plus4"}, pcPlus4, ePc + 32'd4);
        checkVal({name, ".pc_err"}, {31'd0, pcErr}, {31'd0, eErr});
        checkVal({name, ".flush"}, {31'd0, flush}, {31'd0, eFlush});
        checkVal({name, ".pend_valid"}, {31'd0, pendValid}, {31'd0, ePend});
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic applyStimulus(input string name, input vec_t v);
        exp_t e;
        en = v.en; redirValid = v.rv; redirPc = v.rpc;
        excReq = v.exc; eretReq = v.eret; epc = v.epc;
        e.name = name; e.pc = v.pc; e.err = v.err; e.flush = v.flush; e.pend = v.pend;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = scoreboard.pop_front();
            checkState(e.name, e.pc, e.err, e.flush, e.pend);
        end
    endtask

    task automatic runVector(input string name, input vec_t v);
        applyStimulus(name, v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        //                 en rv rpc           exc eret epc           pc            err fl pend
        vecs[0]  = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3004, 0, 0, 0);
        vecs[1]  = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3008, 0, 0, 0);
        vecs[2]  = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_300c, 0, 0, 0);
        vecs[3]  = mk(0, 1, 32'h3100,     0, 0, 32'h0,    32'h0000_300c, 0, 0, 1);
        vecs[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_300c, 0, 0, 1);
        vecs[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_300c, 0, 0, 1);
        vecs[6]  = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3100, 0, 1, 0);
        vecs[7]  = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3104, 0, 0, 0);
        vecs[8]  = mk(0, 1, 32'h3100,     0, 0, 32'h0,    32'h0000_3104, 0, 0, 1);
        vecs[9]  = mk(0, 1, 32'h3200,     0, 0, 32'h0,    32'h0000_3104, 0, 0, 1);
        vecs[10] = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3200, 0, 1, 0);
        vecs[11] = mk(0, 1, 32'h3100,     0, 0, 32'h0,    32'h0000_3200, 0, 0, 1);
        vecs[12] = mk(1, 1, 32'h3300,     0, 0, 32'h0,    32'h0000_3300, 0, 0, 0);
        vecs[13] = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3304, 0, 0, 0);
        vecs[14] = mk(0, 1, 32'h3400,     0, 0, 32'h0,    32'h0000_3304, 0, 0, 1);
        vecs[15] = mk(0, 0, 32'h0,        1, 1, 32'h3040, 32'h0000_4180, 0, 1, 0);
        vecs[16] = mk(0, 0, 32'h0,        0, 1, 32'h3040, 32'h0000_3040, 0, 1, 0);
        vecs[17] = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3044, 0, 0, 0);
        vecs[18] = mk(1, 1, 32'h3002,     0, 0, 32'h0,    32'h0000_3002, 1, 0, 0);
        vecs[19] = mk(1, 1, 32'h2ffc,     0, 0, 32'h0,    32'h0000_2ffc, 1, 0, 0);
        vecs[20] = mk(1, 1, 32'h6ffc,     0, 0, 32'h0,    32'h0000_6ffc, 0, 0, 0);
        vecs[21] = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_7000, 1, 0, 0);
        vecs[22] = mk(0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_7000, 1, 0, 0);
        vecs[23] = mk(1, 1, 32'hffff_fffc, 0, 0, 32'h0,   32'hffff_fffc, 1, 0, 0);
        vecs[24] = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_0000, 1, 0, 0);
        vecs[25] = mk(1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_0004, 1, 0, 0);
        vecs[26] = mk(1, 0, 32'h0,        1, 0, 32'h0,    32'h0000_4180, 0, 1, 0);
        vecs[27] = mk(0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_4180, 0, 0, 0);

        reset = 1'b1; en = 1'b0; redirValid = 1'b0; redirPc = '0;
        excReq = 1'b0; eretReq = 1'b0; epc = '0;
        repeat (2) @(posedge clk);
        #1;
        checkState("reset_hold", 32'h0000_3000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 28; i++)
            runVector($sformatf("vec%0d", i), vecs[i]);

        // Buffer a redirect, then reset asynchronously mid-cycle.
        runVector("stall_pre_reset", mk(0, 1, 32'h3500, 0, 0, 32'h0, 32'h0000_4180, 0, 0, 1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkState("async_reset", 32'h0000_3000, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        @(posedge clk);
        #1;
        checkState("reset_ignores_en", 32'h0000_3000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        runVector("post_reset0", mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3004, 0, 0, 0));
        runVector("post_reset1", mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3008, 0, 0, 0));

        checks++;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries, expected 0", scoreboard.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no completion, expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule
